// File: rtl/sel_mux_arb.sv
// N-channel registered selector with valid/ready handshakes. Selects either an
// externally chosen channel or arbitrates round-robin, feeding a one-entry output stage.
module sel_mux_arb #(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_CH     = 5,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam int PAD_W = 2 ** SEL_WIDTH;

  logic [PTR_W-1:0]      ptr_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [SEL_WIDTH-1:0]  out_ch_r;
  logic                  out_valid_r;

  logic                  load_en_s;
  logic                  xfer_s;
  logic                  grant_valid_s;
  logic [SEL_WIDTH-1:0]  grant_idx_s;
  logic [PAD_W-1:0]      valid_pad_s;
  logic                  fx_valid_s;
  logic                  rr_valid_s;
  logic [SEL_WIDTH-1:0]  rr_idx_s;
  logic [SUM_W-1:0]      rr_sum_s;
  logic [PTR_W-1:0]      rr_pos_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic [PTR_W-1:0]      ptr_next_s;
  logic [NUM_CH-1:0]     in_ready_s;

  // Zero-padding lets an out-of-range sel index safely and read as "not valid".
  assign valid_pad_s = PAD_W'(in_valid);
  assign fx_valid_s  = valid_pad_s[sel];

  // Round-robin scan from ptr; iterating downward makes the nearest valid channel win.
  always_comb begin
    rr_valid_s = 1'b0;
    rr_idx_s   = '0;
    rr_sum_s   = '0;
    rr_pos_s   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      rr_sum_s = {1'b0, ptr_r} + SUM_W'(k);
      if (rr_sum_s >= SUM_W'(NUM_CH)) begin
        rr_sum_s = rr_sum_s - SUM_W'(NUM_CH);
      end else begin
        rr_sum_s = rr_sum_s;
      end
      rr_pos_s = PTR_W'(rr_sum_s);
      if (in_valid[rr_pos_s]) begin
        rr_valid_s = 1'b1;
        rr_idx_s   = SEL_WIDTH'(rr_pos_s);
      end else begin
        rr_valid_s = rr_valid_s;
        rr_idx_s   = rr_idx_s;
      end
    end
  end

  // Grant selection by operating mode.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    if (mode) begin
      grant_valid_s = rr_valid_s;
      grant_idx_s   = rr_idx_s;
    end else begin
      grant_valid_s = fx_valid_s;
      grant_idx_s   = sel;
    end
  end

  assign load_en_s = !out_valid_r || out_ready;
  assign xfer_s    = grant_valid_s && load_en_s && rst_n;

  // One-hot ready for the granted channel and the matching data word.
  always_comb begin
    in_ready_s   = '0;
    grant_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready_s[i] = xfer_s && (grant_idx_s == SEL_WIDTH'(i));
      grant_data_s  = grant_data_s |
                      ((grant_idx_s == SEL_WIDTH'(i)) ? in_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                      : {DATA_WIDTH{1'b0}});
    end
  end

  // Pointer moves just past the served channel, wrapping at NUM_CH.
  always_comb begin
    ptr_next_s = '0;
    if (grant_idx_s == SEL_WIDTH'(NUM_CH - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = PTR_W'(grant_idx_s + SEL_WIDTH'(1));
    end
  end

  // Output stage and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
      ptr_r       <= '0;
    end else if (xfer_s) begin
      out_data_r  <= grant_data_s;
      out_ch_r    <= grant_idx_s;
      out_valid_r <= 1'b1;
      ptr_r       <= ptr_next_s;
    end else if (load_en_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sel_mux_arb.sv
// Randomised and directed bench for sel_mux_arb: a spec-level model predicts grants,
// a scoreboard queue holds expected output words, a monitor checks consumed words.
module tb_sel_mux_arb;

  localparam int DW = 3;
  localparam int NC = 5;
  localparam int SW = 3;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [SW-1:0]    sel;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]    in_valid;
  logic [NC-1:0]    in_ready;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    out_ch;
  logic             out_valid;
  logic             out_ready;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  // reference model state
  int            m_ptr;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_ch;
  int            last_xfer;

  sel_mux_arb #(.DATA_WIDTH(DW), .NUM_CH(NC), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Grant by the plain rules: fixed channel, or first valid scanning from ptr.
  task automatic model_grant(output logic gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < NC) begin
        if (in_valid[sel]) begin
          gv = 1'b1;
          g  = int'(sel);
        end
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (!gv && in_valid[(m_ptr + k) % NC]) begin
          gv = 1'b1;
          g  = (m_ptr + k) % NC;
        end
      end
    end
  endtask

  // Called at negedge+2 with inputs applied; returns at the next negedge+2.
  task automatic tick();
    logic          gv;
    int            g;
    logic          le;
    logic [NC-1:0] er;
    logic [DW-1:0] gd;
    exp_t          e;
    #1;
    model_grant(gv, g);
    le = !m_valid || out_ready;
    er = '0;
    gd = in_data[g*DW +: DW];
    if (gv && le) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    if (gv && le) begin
      e.d = gd;
      e.c = SW'(g);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    last_xfer = -1;
    if (gv && le) begin
      m_valid   = 1'b1;
      m_data    = gd;
      m_ch      = g;
      m_ptr     = (g + 1) % NC;
      last_xfer = g;
    end else if (le) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_ch", 32'(out_ch), 32'(m_ch));
      chk("out_data", 32'(out_data), 32'(m_data));
    end
    #1;
  endtask

  // Asynchronous reset pulse starting at negedge+2, held across one rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    q.delete();
    #9;
    rst_n = 1'b1;
  endtask

  task automatic set_all(input logic v);
    for (int c = 0; c < NC; c++) begin
      in_valid[c]        = v;
      in_data[c*DW +: DW] = DW'(c);
    end
  endtask

  // Scoreboard monitor: one time unit before each rising edge, a consumed word is popped.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got ch %0d data %0h expected no word", out_ch, out_data);
      end else begin
        e = q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.d));
        chk("sb_ch", 32'(out_ch), 32'(e.c));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 3'd0;
    out_ready = 1'b0;
    last_xfer = -1;
    set_all(1'b1);
    #2;
    do_reset();

    // fixed select of ch2
    mode      = 1'b0;
    sel       = 3'd2;
    out_ready = 1'b1;
    set_all(1'b0);
    in_valid  = 5'b00100;
    in_data[2*DW +: DW] = 3'b101;
    tick();
    chk("t1_data", 32'(out_data), 32'd5);
    chk("t1_ch", 32'(out_ch), 32'd2);
    in_valid = 5'b00000;
    tick();
    chk("t1_drop", 32'(out_valid), 32'd0);

    // out-of-range select
    sel = 3'd6;
    set_all(1'b1);
    for (int k = 0; k < 10; k++) tick();

    // round-robin, all valid
    do_reset();
    mode = 1'b1;
    set_all(1'b1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("rr_seq", 32'(out_ch), 32'(k % NC));
      chk("rr_data", 32'(out_data), 32'(k % NC));
    end

    // channels 1 and 3 with stall
    do_reset();
    set_all(1'b0);
    in_valid = 5'b01010;
    in_data[1*DW +: DW] = 3'd6;
    in_data[3*DW +: DW] = 3'd2;
    tick();
    chk("st_first", 32'(out_ch), 32'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    out_ready = 1'b1;
    tick();
    chk("st_ch3", 32'(out_ch), 32'd3);
    tick();
    chk("st_ch1", 32'(out_ch), 32'd1);
    tick();
    chk("st_ch3b", 32'(out_ch), 32'd3);

    // mode switch continues after last served channel
    mode = 1'b0;
    sel  = 3'd3;
    set_all(1'b1);
    tick();
    mode = 1'b1;
    tick();
    chk("sw_ch4", 32'(out_ch), 32'd4);
    tick();
    chk("sw_ch0", 32'(out_ch), 32'd0);

    // reset during a stall
    out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    tick();
    chk("post_rst_ch0", 32'(out_ch), 32'd0);

    // randomised traffic; sources hold valid and data until served
    for (int i = 0; i < 400; i++) begin
      mode = 1'($urandom_range(0, 1));
      sel  = SW'($urandom_range(0, 7));
      for (int c = 0; c < NC; c++) begin
        if (!in_valid[c] || last_xfer == c) begin
          in_valid[c]         = ($urandom_range(0, 2) != 0);
          in_data[c*DW +: DW] = DW'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // drain
    set_all(1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
